// File: rtl/sobel_window_gen_pkg.sv
// Shared Sobel datapath definitions: frame defaults, FSM
// encoding, 3x3 window indices and the win_o packing helper.
package sobel_window_gen_pkg;

  localparam int unsigned DEF_WIDTH  = 640;
  localparam int unsigned DEF_HEIGHT = 480;
  localparam int unsigned DEF_DW     = 8;

  localparam int unsigned WIN_N   = 3;
  localparam int unsigned WIN_TOP = 0;
  localparam int unsigned WIN_MID = 1;
  localparam int unsigned WIN_BOT = 2;
  localparam int unsigned WIN_OLD = 0;
  localparam int unsigned WIN_NEW = 2;

  typedef enum logic {
    ST_FILL,
    ST_STREAM
  } state_t;

  // LSB of element (r,c) inside the packed window bus.
  function automatic int unsigned win_lsb(
    input int unsigned r,
    input int unsigned c,
    input int unsigned dw
  );
    return dw * (WIN_N * r + c);
  endfunction

endpackage

// File: rtl/sobel_window_gen_raster_counter.sv
// Raster position counter (col/row) with end-of-line and
// end-of-frame flags.
//   clk, rst  : clock, sync active-high reset
//   en_i      : advance one pixel
//   col_o/row_o : current (pre-increment) position
//   eol_o/eof_o : current pixel is last of line / frame
module sobel_raster_counter #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  localparam int unsigned CW = $clog2(WIDTH),
  localparam int unsigned RW = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          eol_o,
  output logic          eof_o
);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_eol;
  logic          w_eof;

  assign w_eol = (r_col == COL_LAST);
  assign w_eof = w_eol & (r_row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (en_i) begin
      if (w_eol) begin
        r_col <= '0;
        r_row <= w_eof ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign col_o = r_col;
  assign row_o = r_row;
  assign eol_o = w_eol;
  assign eof_o = w_eof;

endmodule

// File: rtl/sobel_window_gen.sv
// Line-buffer controller and registered 3x3 window generator
// for the Sobel stage.
//   pix_valid_i/pix_i       : raster pixel stream
//   lb0_*/lb1_*             : two external single-line FIFOs
//   win_o/win_valid_o       : packed window + interior strobe
//   win_row_o/win_col_o     : window centre coordinates
//   frame_done_o            : pulse after last frame pixel
module sobel_window_gen
  import sobel_window_gen_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT,
  parameter int unsigned DW     = DEF_DW,
  localparam int unsigned CW = $clog2(WIDTH),
  localparam int unsigned RW = $clog2(HEIGHT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pix_valid_i,
  input  logic [DW-1:0]   pix_i,
  output logic            lb0_we_o,
  output logic [DW-1:0]   lb0_data_o,
  input  logic [DW-1:0]   lb0_q_i,
  input  logic            lb0_done_i,
  output logic            lb1_we_o,
  output logic [DW-1:0]   lb1_data_o,
  input  logic [DW-1:0]   lb1_q_i,
  output logic [9*DW-1:0] win_o,
  output logic            win_valid_o,
  output logic [RW-1:0]   win_row_o,
  output logic [CW-1:0]   win_col_o,
  output logic            frame_done_o
);

  logic [CW-1:0]   w_col;
  logic [RW-1:0]   w_row;
  logic            w_eol;
  logic            w_eof;
  logic            w_acc;
  logic            w_valid;
  logic [9*DW-1:0] w_win_nxt;
  state_t          w_state_nxt;

  state_t          r_state;
  logic [9*DW-1:0] r_win;
  logic            r_valid;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic            r_done;

  assign w_acc = pix_valid_i;

  // Same-cycle read data is the pixel one row above, so
  // lb0 feeds lb1 to get the pixel two rows above.
  assign lb0_we_o   = pix_valid_i;
  assign lb0_data_o = pix_i;
  assign lb1_we_o   = pix_valid_i & lb0_done_i;
  assign lb1_data_o = lb0_q_i;

  sobel_raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (w_acc),
    .col_o (w_col),
    .row_o (w_row),
    .eol_o (w_eol),
    .eof_o (w_eof)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    unique case (r_state)
      ST_FILL: begin
        if (w_acc && w_eol && w_row == RW'(1))
          w_state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        w_valid = w_acc
                & (w_row >= RW'(2))
                & (w_col >= CW'(2));
        if (w_acc && w_eof)
          w_state_nxt = ST_FILL;
      end
    endcase
  end

  always_comb begin
    w_win_nxt = r_win;
    for (int unsigned r = 0; r < WIN_N; r++) begin
      for (int unsigned c = WIN_OLD; c < WIN_NEW; c++) begin
        w_win_nxt[win_lsb(r, c, DW) +: DW] =
          r_win[win_lsb(r, c + 1, DW) +: DW];
      end
    end
    w_win_nxt[win_lsb(WIN_TOP, WIN_NEW, DW) +: DW] = lb1_q_i;
    w_win_nxt[win_lsb(WIN_MID, WIN_NEW, DW) +: DW] = lb0_q_i;
    w_win_nxt[win_lsb(WIN_BOT, WIN_NEW, DW) +: DW] = pix_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
      r_win   <= '0;
      r_valid <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid;
      r_done  <= w_acc & w_eof;
      if (w_acc) begin
        r_win <= w_win_nxt;
        r_row <= w_row - 1'b1;
        r_col <= w_col - 1'b1;
      end
    end
  end

  assign win_o        = r_win;
  assign win_valid_o  = r_valid;
  assign win_row_o    = r_row;
  assign win_col_o    = r_col;
  assign frame_done_o = r_done;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 5x4 frame with
// behavioural line-buffer FIFOs.
module tb_sobel_window_gen;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pix_valid_i = 1'b0;
  logic [DW-1:0]   pix_i = '0;
  logic            lb0_we_o;
  logic [DW-1:0]   lb0_data_o;
  logic [DW-1:0]   lb0_q_i;
  logic            lb0_done_i;
  logic            lb1_we_o;
  logic [DW-1:0]   lb1_data_o;
  logic [DW-1:0]   lb1_q_i;
  logic [9*DW-1:0] win_o;
  logic            win_valid_o;
  logic [1:0]      win_row_o;
  logic [2:0]      win_col_o;
  logic            frame_done_o;

  always #5 clk = ~clk;

  sobel_window_gen #(
    .WIDTH  (W),
    .HEIGHT (H),
    .DW     (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid_i  (pix_valid_i),
    .pix_i        (pix_i),
    .lb0_we_o     (lb0_we_o),
    .lb0_data_o   (lb0_data_o),
    .lb0_q_i      (lb0_q_i),
    .lb0_done_i   (lb0_done_i),
    .lb1_we_o     (lb1_we_o),
    .lb1_data_o   (lb1_data_o),
    .lb1_q_i      (lb1_q_i),
    .win_o        (win_o),
    .win_valid_o  (win_valid_o),
    .win_row_o    (win_row_o),
    .win_col_o    (win_col_o),
    .frame_done_o (frame_done_o)
  );

  // Line-buffer models: DEPTH=W FIFOs, read shows oldest entry.
  logic [DW-1:0] lb0_mem [W];
  logic [DW-1:0] lb1_mem [W];
  logic [2:0]    lb0_ptr, lb0_cnt, lb1_ptr, lb1_cnt;

  assign lb0_q_i    = lb0_mem[lb0_ptr];
  assign lb1_q_i    = lb1_mem[lb1_ptr];
  assign lb0_done_i = (lb0_cnt == 3'(W));

  always @(posedge clk) begin
    if (rst) begin
      lb0_ptr <= '0; lb0_cnt <= '0;
      lb1_ptr <= '0; lb1_cnt <= '0;
      for (int i = 0; i < W; i++) begin
        lb0_mem[i] <= '0;
        lb1_mem[i] <= '0;
      end
    end else begin
      if (lb0_we_o) begin
        lb0_mem[lb0_ptr] <= lb0_data_o;
        lb0_ptr <= (lb0_ptr == 3'(W-1)) ? '0 : lb0_ptr + 3'd1;
        if (lb0_cnt < 3'(W)) lb0_cnt <= lb0_cnt + 3'd1;
      end
      if (lb1_we_o) begin
        lb1_mem[lb1_ptr] <= lb1_data_o;
        lb1_ptr <= (lb1_ptr == 3'(W-1)) ? '0 : lb1_ptr + 3'd1;
        if (lb1_cnt < 3'(W)) lb1_cnt <= lb1_cnt + 3'd1;
      end
    end
  end

  typedef struct packed {
    logic            v;
    logic            fd;
    logic [1:0]      r;
    logic [2:0]      c;
    logic [9*DW-1:0] w;
  } exp_t;

  exp_t            sb[$];
  exp_t            e;
  int              n_vec = 0;
  int              n_err = 0;
  int              m_row = 0, m_col = 0;
  int              l_row = 0, l_col = 0;
  logic            s_we;
  logic [DW-1:0]   s_data;
  logic [9*DW-1:0] p_win;
  logic [1:0]      p_row;
  logic [2:0]      p_col;

  // Drive one cycle; for an accepted pixel push the expected
  // window built from the pixel formula 16*row+col.
  task automatic step(input bit v);
    exp_t x;
    p_win = win_o; p_row = win_row_o; p_col = win_col_o;
    @(negedge clk);
    pix_valid_i = v;
    pix_i = v ? DW'(16*m_row + m_col) : '0;
    #1;
    s_we   = lb1_we_o;
    s_data = lb1_data_o;
    if (v) begin
      x    = '0;
      x.v  = (m_row >= 2) && (m_col >= 2);
      x.fd = (m_row == H-1) && (m_col == W-1);
      x.r  = 2'(m_row - 1);
      x.c  = 3'(m_col - 1);
      if (x.v)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            x.w[DW*(3*r+c) +: DW] =
              DW'(16*(m_row-2+r) + (m_col-2+c));
      sb.push_back(x);
      l_row = m_row; l_col = m_col;
      if (m_col == W-1) begin
        m_col = 0;
        m_row = (m_row == H-1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    @(posedge clk);
    #1;
    pix_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_row = 0; m_col = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (win_o !== '0 || win_valid_o !== 1'b0 ||
        win_row_o !== '0 || win_col_o !== '0 ||
        frame_done_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: win=%h v=%b r=%0d c=%0d fd=%b, required all 0",
               win_o, win_valid_o, win_row_o, win_col_o, frame_done_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_continuous();
    int nwin = 0;
    logic [9*DW-1:0] first_w;
    first_w = {8'd34, 8'd33, 8'd32, 8'd18, 8'd17, 8'd16,
               8'd2, 8'd1, 8'd0};
    for (int k = 0; k < W*H; k++) begin
      step(1'b1);
      e = sb.pop_front();
      n_vec++;
      if (win_valid_o !== e.v || frame_done_o !== e.fd) begin
        n_err++;
        $display("FAIL cont_strobe px(%0d,%0d): v/fd=%b%b required %b%b",
                 l_row, l_col, win_valid_o, frame_done_o, e.v, e.fd);
      end
      if (e.v) begin
        n_vec++;
        if (win_o !== e.w || win_row_o !== e.r || win_col_o !== e.c) begin
          n_err++;
          $display("FAIL cont_win: %h (%0d,%0d) required %h (%0d,%0d)",
                   win_o, win_row_o, win_col_o, e.w, e.r, e.c);
        end
      end
      if (win_valid_o === 1'b1 && nwin == 0) begin
        n_vec++;
        if (l_row != 2 || l_col != 2 || win_row_o !== 2'd1 ||
            win_col_o !== 3'd1 || win_o !== first_w) begin
          n_err++;
          $display("FAIL cont_first: px(%0d,%0d) c(%0d,%0d) %h required px(2,2) c(1,1) %h",
                   l_row, l_col, win_row_o, win_col_o, win_o, first_w);
        end
      end
      if (frame_done_o === 1'b1) begin
        n_vec++;
        if (win_valid_o !== 1'b1 || win_row_o !== 2'd2 ||
            win_col_o !== 3'd3 || win_o[71:48] !== {8'd52, 8'd51, 8'd50}) begin
          n_err++;
          $display("FAIL cont_last: v=%b c(%0d,%0d) bot=%h required 1 c(2,3) 343332",
                   win_valid_o, win_row_o, win_col_o, win_o[71:48]);
        end
      end
      if (win_valid_o === 1'b1) nwin++;
    end
    n_vec++;
    if (nwin != 6) begin
      n_err++;
      $display("FAIL cont_count: %0d windows, required 6", nwin);
    end
  endtask

  task automatic test_gaps();
    int nwin = 0;
    int acc  = 0;
    bit v;
    for (int i = 0; i < 400 && acc < W*H; i++) begin
      v = 1'($urandom_range(0, 1));
      step(v);
      if (v) begin
        acc++;
        e = sb.pop_front();
        n_vec++;
        if (win_valid_o !== e.v || frame_done_o !== e.fd) begin
          n_err++;
          $display("FAIL gap_strobe px(%0d,%0d): v/fd=%b%b required %b%b",
                   l_row, l_col, win_valid_o, frame_done_o, e.v, e.fd);
        end
        if (e.v) begin
          n_vec++;
          if (win_o !== e.w || win_row_o !== e.r || win_col_o !== e.c) begin
            n_err++;
            $display("FAIL gap_win: %h (%0d,%0d) required %h (%0d,%0d)",
                     win_o, win_row_o, win_col_o, e.w, e.r, e.c);
          end
        end
        if (win_valid_o === 1'b1) nwin++;
      end else begin
        n_vec++;
        if (win_valid_o !== 1'b0 || frame_done_o !== 1'b0 ||
            win_o !== p_win || win_row_o !== p_row || win_col_o !== p_col) begin
          n_err++;
          $display("FAIL gap_hold: v=%b fd=%b %h (%0d,%0d) required 0 0 %h (%0d,%0d)",
                   win_valid_o, frame_done_o, win_o, win_row_o, win_col_o,
                   p_win, p_row, p_col);
        end
      end
    end
    n_vec++;
    if (acc != W*H || nwin != 6) begin
      n_err++;
      $display("FAIL gap_count: %0d pixels %0d windows, required 20 and 6",
               acc, nwin);
    end
  endtask

  task automatic test_back_to_back();
    int nwin = 0, nfd = 0, nbad = 0;
    for (int k = 0; k < 2*W*H; k++) begin
      step(1'b1);
      e = sb.pop_front();
      n_vec++;
      if (win_valid_o !== e.v || frame_done_o !== e.fd) begin
        n_err++;
        $display("FAIL b2b_strobe px(%0d,%0d): v/fd=%b%b required %b%b",
                 l_row, l_col, win_valid_o, frame_done_o, e.v, e.fd);
      end
      if (e.v) begin
        n_vec++;
        if (win_o !== e.w || win_row_o !== e.r || win_col_o !== e.c) begin
          n_err++;
          $display("FAIL b2b_win: %h (%0d,%0d) required %h (%0d,%0d)",
                   win_o, win_row_o, win_col_o, e.w, e.r, e.c);
        end
      end
      if (win_valid_o === 1'b1) nwin++;
      if (frame_done_o === 1'b1) nfd++;
      if (k >= W*H && l_row < 2 && win_valid_o !== 1'b0) nbad++;
    end
    n_vec++;
    if (nwin != 12 || nfd != 2 || nbad != 0) begin
      n_err++;
      $display("FAIL b2b_count: win=%0d fd=%0d stale=%0d, required 12 2 0",
               nwin, nfd, nbad);
    end
  endtask

  task automatic test_mid_reset();
    int nwin = 0;
    for (int k = 0; k < 2*W + 4; k++) begin
      step(1'b1);
      e = sb.pop_front();
      n_vec++;
      if (win_valid_o !== e.v) begin
        n_err++;
        $display("FAIL mrst_pre px(%0d,%0d): v=%b required %b",
                 l_row, l_col, win_valid_o, e.v);
      end
    end
    do_reset();
    n_vec++;
    if (win_o !== '0 || win_valid_o !== 1'b0 ||
        win_row_o !== '0 || win_col_o !== '0 ||
        frame_done_o !== 1'b0) begin
      n_err++;
      $display("FAIL mrst_zero: win=%h v=%b r=%0d c=%0d fd=%b, required all 0",
               win_o, win_valid_o, win_row_o, win_col_o, frame_done_o);
    end
    for (int k = 0; k < W*H; k++) begin
      step(1'b1);
      e = sb.pop_front();
      n_vec++;
      if (win_valid_o !== e.v || frame_done_o !== e.fd) begin
        n_err++;
        $display("FAIL mrst_strobe px(%0d,%0d): v/fd=%b%b required %b%b",
                 l_row, l_col, win_valid_o, frame_done_o, e.v, e.fd);
      end
      if (e.v) begin
        n_vec++;
        if (win_o !== e.w || win_row_o !== e.r || win_col_o !== e.c) begin
          n_err++;
          $display("FAIL mrst_win: %h (%0d,%0d) required %h (%0d,%0d)",
                   win_o, win_row_o, win_col_o, e.w, e.r, e.c);
        end
      end
      if (win_valid_o === 1'b1) nwin++;
    end
    n_vec++;
    if (nwin != 6) begin
      n_err++;
      $display("FAIL mrst_count: %0d windows, required 6", nwin);
    end
  endtask

  task automatic test_lb1_we();
    logic [DW-1:0] want;
    do_reset();
    for (int k = 0; k < W*H; k++) begin
      want = DW'(k/W*16 + k%W - 16);
      step(1'b1);
      void'(sb.pop_front());
      n_vec++;
      if (s_we !== (k >= W)) begin
        n_err++;
        $display("FAIL lb1_we px#%0d: %b required %b", k, s_we, k >= W);
      end
      if (k >= W) begin
        n_vec++;
        if (s_data !== want) begin
          n_err++;
          $display("FAIL lb1_data px#%0d: %0d required %0d", k, s_data, want);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_lb1_we();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

- Reader/controller side of the edge-detection line-buffer chain.
- Consumes the raster pixel stream and drives two cascaded single-line FIFO buffers, each DEPTH = WIDTH, placed outside this block.
- Assembles their outputs with the live pixel into a registered 3x3 window, with a valid strobe and centre coordinates.
- Feeds the Sobel gradient stage. Windows touching the image border are suppressed.

## Interface

- WIDTH, 640, pixels per line; also the DEPTH of both external line buffers
- HEIGHT, 480, lines per frame
- DW, 8, pixel width in bits
- clk  in  1  system clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- pix_valid_i  in  1  pixel accepted this cycle; no backpressure
- pix_i  in  DW  raster-order pixel
- lb0_we_o  out  1  line buffer 0 write enable; equals pix_valid_i (combinational)
- lb0_data_o  out  DW  line buffer 0 write data; equals pix_i
- lb0_q_i  in  DW  line buffer 0 read data (pixel one row above)
- lb0_done_i  in  1  line buffer 0 holds a full line
- lb1_we_o  out  1  pix_valid_i & lb0_done_i
- lb1_data_o  out  DW  equals lb0_q_i
- lb1_q_i  in  DW  line buffer 1 read data (pixel two rows above)
- win_o  out  9*DW  window; element (r,c) at bits [DW*(3r+c) +: DW], r=0 top row, c=0 oldest column
- win_valid_o  out  1  win_o holds a full interior window
- win_row_o  out  clog2(HEIGHT)  row of the window centre
- win_col_o  out  clog2(WIDTH)  column of the window centre
- frame_done_o  out  1  one-cycle pulse after the last pixel of a frame

## Operation

- **Line buffer read data:**
  - Line buffer read data is combinational and shows the oldest entry.
  - Sampled in the same cycle as the write, it is the pixel at the same column one row up.
- **Window shift:** on each accepted pixel, all three window rows shift left by one column.
  - New column: top = lb1_q_i, mid = lb0_q_i, bottom = pix_i.
- **Counters:**
  - col counts 0..WIDTH-1 and wraps to 0.
  - row increments on col wrap and wraps to 0 after HEIGHT-1.
  - Both counters update only on accepted pixels.
- **Valid rule:** evaluated on pre-increment counters of the accepted pixel.
  - Window is valid iff row ≥ 2 and col ≥ 2.
  - Centre coordinates = (row-1, col-1).
- **FSM:**
  - ST_FILL: row < 2. Window shifts but win_valid_o stays 0.
  - ST_FILL → ST_STREAM on acceptance of pixel (1, WIDTH-1).
  - ST_STREAM: valid per the rule above.
  - ST_STREAM → ST_FILL on acceptance of pixel (HEIGHT-1, WIDTH-1); that same acceptance raises frame_done_o and zeroes the counters.
- **Line buffers across frames:**
  - Line buffers are not flushed between frames.
  - Stale data in rows 0–1 of the next frame is masked by ST_FILL.
- **Width rules:**
  - Counters are unsigned, sized clog2 of their limit.
  - Comparisons are against WIDTH-1 and HEIGHT-1.
  - No pixel arithmetic is done in this block.

## Timing

- Latency:
  - Pixel accepted at edge N → win_o, win_valid_o, win_row_o, win_col_o and frame_done_o are valid in cycle N+1.
  - These outputs are registered.
- win_valid_o and frame_done_o are single-cycle pulses per accepted pixel.
- win_o, win_row_o and win_col_o hold their values when no pixel is accepted.
- Idle cycles (pix_valid_i = 0): no shift, no counter change, win_valid_o = 0, frame_done_o = 0.
- Reset values:
  - win_o = 0, win_valid_o = 0, win_row_o = 0, win_col_o = 0, frame_done_o = 0.
  - col = 0, row = 0, state = ST_FILL.
- Reset mid-frame:
  - Block restarts at pixel (0,0) on the next accepted pixel.
  - The external line buffers share rst, so lb0_done_i drops to 0.
- Last pixel of a frame: win_valid_o and frame_done_o assert in the same cycle.

## Structure

- Shared package, owned by the Sobel datapath:
  - Window index constants and the win_o packing function.
  - State encoding: ST_FILL, ST_STREAM.
  - Default WIDTH, HEIGHT and DW.
- Sub-module sobel_raster_counter:
  - Holds col/row, with wrap, end-of-line and end-of-frame flags.
  - Enable input = pix_valid_i.
- Window registers and the FSM live in the top module.

## Test plan

Bench setup: WIDTH=5, HEIGHT=4, two line-buffer models with DEPTH=5, pixel value = 16*row+col.
- **Continuous frame:**
  - Exactly 6 win_valid_o pulses.
  - First pulse one cycle after pixel (2,2), with centre (1,1) and win_o rows {0,1,2}/{16,17,18}/{32,33,34}.
  - Last pulse coincides with frame_done_o, centre (2,3), window bottom row {50,51,52}.
- **Random pix_valid_i gaps (50% duty):**
  - Same 6 windows, in the same order, with identical contents.
  - Outputs hold, and no pulses occur, during gaps.
- **Back-to-back frames (40 pixels):**
  - Two frame_done_o pulses, 12 windows total.
  - No valid windows during row 0–1 of frame 2, despite stale line-buffer data.
- **rst asserted after pixel (2,3):**
  - All outputs are 0 the next cycle.
  - Restarting a full frame yields the exact 6-window sequence.
- **lb1_we_o check:**
  - Low for the first 5 accepted pixels.
  - High for every accepted pixel afterwards.
  - lb1_data_o equals the row-above pixel value (pixel − 16) for each write.
